// File: rtl/serdesphy_pll_autocal.sv
`default_nettype none
// ============================================================================
// Module   : serdesphy_pll_autocal
// Brief    : SerDes PHY PLL controller on the 24 MHz reference domain.
//            Sequences the analog PLL macro through reset, settle and lock
//            acquisition, searches VCO trim bands automatically when cal_en
//            is set, retries a bounded number of times, counts loss-of-lock
//            events and gates the 240 MHz TX/RX clock enable on lock.
// Revision : 1.0  initial release
// ============================================================================
module serdesphy_pll_autocal #(
  parameter int TRIM_W      = 4,
  parameter int CP_W        = 2,
  parameter int CNT_W       = 16,
  parameter int RST_PULSE   = 16,
  parameter int SETTLE_CNT  = 480,
  parameter int LOCK_CNT    = 2400,
  parameter int UNLOCK_CNT  = 240,
  parameter int ACQ_TIMEOUT = 4800,
  parameter int MAX_RETRY   = 3
) (
  input  logic              clk_ref_24m,
  input  logic              rst_n,
  input  logic              phy_en,
  input  logic              pll_rst,
  input  logic              pll_bypass,
  input  logic              cal_en,
  input  logic [TRIM_W-1:0] vco_trim_man,
  input  logic [CP_W-1:0]   cp_current,
  input  logic              pll_lock_raw,
  input  logic              pll_vco_ok,
  input  logic              pll_cp_ok,
  output logic              pll_enable,
  output logic              pll_reset_n,
  output logic              pll_bypass_en,
  output logic [TRIM_W-1:0] pll_vco_trim,
  output logic [CP_W-1:0]   pll_cp_current,
  output logic              pll_lock,
  output logic              pll_error,
  output logic              clk_240m_en,
  output logic [TRIM_W-1:0] cal_trim,
  output logic [1:0]        retry_cnt,
  output logic [7:0]        lol_cnt,
  output logic [2:0]        state
);

  // Terminal counts: a window of N cycles ends when the counter holds N-1.
  localparam logic [CNT_W-1:0]  c_RST_LAST    = CNT_W'(RST_PULSE - 1);
  localparam logic [CNT_W-1:0]  c_SETTLE_LAST = CNT_W'(SETTLE_CNT - 1);
  localparam logic [CNT_W-1:0]  c_LOCK_LAST   = CNT_W'(LOCK_CNT - 1);
  localparam logic [CNT_W-1:0]  c_UNLOCK_LAST = CNT_W'(UNLOCK_CNT - 1);
  localparam logic [CNT_W-1:0]  c_TMO_LAST    = CNT_W'(ACQ_TIMEOUT - 1);
  localparam logic [TRIM_W-1:0] c_TRIM_MID    = TRIM_W'(1 << (TRIM_W - 1));
  localparam logic [TRIM_W-1:0] c_TRIM_MAX    = {TRIM_W{1'b1}};
  localparam logic [1:0]        c_MAX_RETRY   = 2'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RESTART = 3'd1,
    S_SETTLE  = 3'd2,
    S_ACQUIRE = 3'd3,
    S_LOCKED  = 3'd4,
    S_ERROR   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [TRIM_W-1:0] trim_q, trim_d;
  logic [TRIM_W-1:0] cal_trim_q, cal_trim_d;
  logic [TRIM_W-1:0] man_q;
  logic              cal_mode_q, cal_mode_d;
  logic [CNT_W-1:0]  tmr_q, tmr_d;     // phase timer: reset pulse, settle, acquire timeout
  logic [CNT_W-1:0]  run_q, run_d;     // consecutive good (ACQUIRE) or bad (LOCKED) cycles
  logic [1:0]        retry_q, retry_d;
  logic [7:0]        lol_q, lol_d;
  logic              bypass_q;
  logic [CP_W-1:0]   cp_q;

  logic              w_run;
  logic              w_good;
  logic              w_retune;
  logic              w_reenter;
  logic [TRIM_W-1:0] w_reload_trim;

  assign w_run  = phy_en & ~pll_rst & ~pll_bypass;
  assign w_good = pll_lock_raw & pll_vco_ok & pll_cp_ok;

  // A manual trim edit only retunes once the PLL has left its reset phase.
  assign w_retune = ~cal_mode_q && (vco_trim_man != man_q) &&
                    ((state_q == S_SETTLE) || (state_q == S_ACQUIRE) ||
                     (state_q == S_LOCKED));

  // Starting trim for a fresh run or a retry: bottom of the band in auto mode.
  assign w_reload_trim = cal_mode_q ? '0 : vco_trim_man;

  // Next-state, trim, counters and timer decisions.
  always_comb begin
    state_d    = state_q;
    trim_d     = trim_q;
    cal_trim_d = cal_trim_q;
    cal_mode_d = cal_mode_q;
    retry_d    = retry_q;
    lol_d      = lol_q;
    tmr_d      = tmr_q;
    run_d      = run_q;
    w_reenter  = 1'b0;

    if (!w_run) begin
      state_d = S_IDLE;
      retry_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          retry_d    = '0;
          state_d    = S_RESTART;
          cal_mode_d = cal_en;
          trim_d     = cal_en ? '0 : vco_trim_man;
        end

        S_RESTART: begin
          tmr_d = tmr_q + 1'b1;
          if (tmr_q == c_RST_LAST) begin
            state_d = S_SETTLE;
          end
        end

        S_SETTLE: begin
          tmr_d = tmr_q + 1'b1;
          if (w_retune) begin
            trim_d    = vco_trim_man;
            w_reenter = 1'b1;
          end else if (tmr_q == c_SETTLE_LAST) begin
            state_d = S_ACQUIRE;
          end
        end

        S_ACQUIRE: begin
          tmr_d = tmr_q + 1'b1;
          run_d = w_good ? run_q + 1'b1 : '0;
          if (w_retune) begin
            trim_d  = vco_trim_man;
            state_d = S_SETTLE;
          end else if (w_good && (run_q == c_LOCK_LAST)) begin
            // Lock takes priority over a timeout landing on the same cycle.
            state_d    = S_LOCKED;
            cal_trim_d = trim_q;
          end else if (tmr_q == c_TMO_LAST) begin
            if (cal_mode_q && (trim_q != c_TRIM_MAX)) begin
              trim_d  = trim_q + 1'b1;
              state_d = S_SETTLE;
            end else if (retry_q < c_MAX_RETRY) begin
              retry_d = retry_q + 1'b1;
              trim_d  = w_reload_trim;
              state_d = S_RESTART;
            end else begin
              state_d = S_ERROR;
            end
          end
        end

        S_LOCKED: begin
          run_d = w_good ? '0 : run_q + 1'b1;
          if (w_retune) begin
            trim_d  = vco_trim_man;
            state_d = S_SETTLE;
          end else if (!w_good && (run_q == c_UNLOCK_LAST)) begin
            state_d = S_SETTLE;
            retry_d = '0;
            if (lol_q != 8'hFF) begin
              lol_d = lol_q + 8'd1;
            end
          end
        end

        S_ERROR: begin
          state_d = S_ERROR;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // Every state entry (including a retune back into SETTLE) restarts timing.
    if ((state_d != state_q) || w_reenter) begin
      tmr_d = '0;
      run_d = '0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_ref_24m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Trim, calibration result, retry/loss-of-lock counters and timers.
  always_ff @(posedge clk_ref_24m or negedge rst_n) begin
    if (!rst_n) begin
      trim_q     <= c_TRIM_MID;
      cal_trim_q <= '0;
      cal_mode_q <= 1'b0;
      retry_q    <= '0;
      lol_q      <= '0;
      tmr_q      <= '0;
      run_q      <= '0;
    end else begin
      trim_q     <= trim_d;
      cal_trim_q <= cal_trim_d;
      cal_mode_q <= cal_mode_d;
      retry_q    <= retry_d;
      lol_q      <= lol_d;
      tmr_q      <= tmr_d;
      run_q      <= run_d;
    end
  end

  // CSR pass-through registers and the manual-trim history for edit detection.
  always_ff @(posedge clk_ref_24m or negedge rst_n) begin
    if (!rst_n) begin
      bypass_q <= 1'b0;
      cp_q     <= '0;
      man_q    <= '0;
    end else begin
      bypass_q <= phy_en & pll_bypass;
      cp_q     <= cp_current;
      man_q    <= vco_trim_man;
    end
  end

  // Moore outputs decoded straight from registered state.
  assign pll_enable     = (state_q == S_RESTART) || (state_q == S_SETTLE) ||
                          (state_q == S_ACQUIRE) || (state_q == S_LOCKED);
  assign pll_reset_n    = (state_q == S_SETTLE) || (state_q == S_ACQUIRE) ||
                          (state_q == S_LOCKED);
  assign pll_lock       = (state_q == S_LOCKED);
  assign clk_240m_en    = (state_q == S_LOCKED);
  assign pll_error      = (state_q == S_ERROR);
  assign pll_bypass_en  = bypass_q;
  assign pll_vco_trim   = trim_q;
  assign pll_cp_current = cp_q;
  assign cal_trim       = cal_trim_q;
  assign retry_cnt      = retry_q;
  assign lol_cnt        = lol_q;
  assign state          = state_q;

endmodule
`default_nettype wire

// File: tb/tb_serdesphy_pll_autocal.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_serdesphy_pll_autocal
// Brief    : Randomized self-checking bench; expected timings are derived from
//            the phase lengths with plain arithmetic.
// Revision : 1.0  initial release
// ============================================================================
module tb_serdesphy_pll_autocal;

  localparam int TRIM_W      = 4;
  localparam int CP_W        = 2;
  localparam int RST_PULSE   = 2;
  localparam int SETTLE_CNT  = 4;
  localparam int LOCK_CNT    = 8;
  localparam int UNLOCK_CNT  = 4;
  localparam int ACQ_TIMEOUT = 16;
  localparam int MAX_RETRY   = 2;
  localparam int TRIM_MID    = 1 << (TRIM_W - 1);
  localparam int TRIM_MAX    = (1 << TRIM_W) - 1;

  logic              clk_ref_24m = 1'b0;
  logic              rst_n;
  logic              phy_en, pll_rst, pll_bypass, cal_en;
  logic [TRIM_W-1:0] vco_trim_man;
  logic [CP_W-1:0]   cp_current;
  logic              pll_lock_raw, pll_vco_ok, pll_cp_ok;
  logic              pll_enable, pll_reset_n, pll_bypass_en, pll_lock, pll_error, clk_240m_en;
  logic [TRIM_W-1:0] pll_vco_trim, cal_trim;
  logic [CP_W-1:0]   pll_cp_current;
  logic [1:0]        retry_cnt;
  logic [7:0]        lol_cnt;
  logic [2:0]        state;

  // Analog macro model: {lock_raw, vco_ok, cp_ok} forced bits, and in auto
  // mode the lock only appears on the target trim band.
  logic [2:0]        ok_v;
  logic              auto_good;
  logic [TRIM_W-1:0] target;
  assign pll_lock_raw = ok_v[2] & (~auto_good | (pll_vco_trim == target));
  assign pll_vco_ok   = ok_v[1];
  assign pll_cp_ok    = ok_v[0];

  always #5 clk_ref_24m = ~clk_ref_24m;

  serdesphy_pll_autocal #(
    .TRIM_W(TRIM_W), .CP_W(CP_W), .CNT_W(16), .RST_PULSE(RST_PULSE),
    .SETTLE_CNT(SETTLE_CNT), .LOCK_CNT(LOCK_CNT), .UNLOCK_CNT(UNLOCK_CNT),
    .ACQ_TIMEOUT(ACQ_TIMEOUT), .MAX_RETRY(MAX_RETRY)
  ) dut (
    .clk_ref_24m(clk_ref_24m), .rst_n(rst_n), .phy_en(phy_en), .pll_rst(pll_rst),
    .pll_bypass(pll_bypass), .cal_en(cal_en), .vco_trim_man(vco_trim_man),
    .cp_current(cp_current), .pll_lock_raw(pll_lock_raw), .pll_vco_ok(pll_vco_ok),
    .pll_cp_ok(pll_cp_ok), .pll_enable(pll_enable), .pll_reset_n(pll_reset_n),
    .pll_bypass_en(pll_bypass_en), .pll_vco_trim(pll_vco_trim),
    .pll_cp_current(pll_cp_current), .pll_lock(pll_lock), .pll_error(pll_error),
    .clk_240m_en(clk_240m_en), .cal_trim(cal_trim), .retry_cnt(retry_cnt),
    .lol_cnt(lol_cnt), .state(state)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [4:0] hist[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_ref_24m);
    #1;
  endtask

  // Reference timing model, in edges counted from the first edge seeing run=1.
  function automatic int manual_lock_edges();
    return 1 + RST_PULSE + SETTLE_CNT + LOCK_CNT;
  endfunction
  function automatic int auto_lock_edges(input int t);
    return 1 + RST_PULSE + t * (SETTLE_CNT + ACQ_TIMEOUT) + SETTLE_CNT + LOCK_CNT;
  endfunction
  function automatic int manual_attempt_end(input int k);
    return 1 + k * (RST_PULSE + SETTLE_CNT + ACQ_TIMEOUT);
  endfunction

  // Steps until lock or budget; records {enable, reset_n, state} per edge.
  task automatic wait_lock(input int budget, output int edges);
    edges = 0;
    hist.delete();
    while (!pll_lock && edges < budget) begin
      tick();
      edges++;
      hist.push_back({pll_enable, pll_reset_n, state});
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"},    32'(state), 0);
    check({tag, "_trim"},     32'(pll_vco_trim), TRIM_MID);
    check({tag, "_cp"},       32'(pll_cp_current), 0);
    check({tag, "_enable"},   32'(pll_enable), 0);
    check({tag, "_reset_n"},  32'(pll_reset_n), 0);
    check({tag, "_lock"},     32'(pll_lock), 0);
    check({tag, "_clk_en"},   32'(clk_240m_en), 0);
    check({tag, "_error"},    32'(pll_error), 0);
    check({tag, "_bypass"},   32'(pll_bypass_en), 0);
    check({tag, "_cal_trim"}, 32'(cal_trim), 0);
    check({tag, "_retry"},    32'(retry_cnt), 0);
    check({tag, "_lol"},      32'(lol_cnt), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, m, m2, nbad, b, t, tmax, r1, r2;
    logic [CP_W-1:0] cp0, cp1;

    rst_n = 1'b0; phy_en = 1'b0; pll_rst = 1'b0; pll_bypass = 1'b1; cal_en = 1'b0;
    vco_trim_man = '0; ok_v = 3'b111; auto_good = 1'b0; target = '0;
    cp0 = CP_W'($urandom_range(1, 3));
    cp_current = cp0;
    phy_en = 1'b1;
    tick(); tick();
    check_reset_outputs("reset");
    phy_en = 1'b0; pll_bypass = 1'b0;
    rst_n = 1'b1;
    tick();

    // Manual lock at a random trim.
    m = $urandom_range(0, TRIM_MAX);
    vco_trim_man = TRIM_W'(m);
    phy_en = 1'b1;
    wait_lock(64, e);
    check("man_lock_edges", e, manual_lock_edges());
    check("man_restart_phase", 32'(hist[0]), 32'(5'b10_001));
    check("man_settle_phase",  32'(hist[RST_PULSE]), 32'(5'b11_010));
    check("man_acquire_phase", 32'(hist[RST_PULSE + SETTLE_CNT]), 32'(5'b11_011));
    check("man_cal_trim", 32'(cal_trim), m);
    check("man_trim",     32'(pll_vco_trim), m);
    check("man_clk_en",   32'(clk_240m_en), 1);
    check("man_retry",    32'(retry_cnt), 0);
    check("man_state",    32'(state), 4);
    check("man_cp",       32'(pll_cp_current), 32'(cp0));

    // Charge-pump select follows with one cycle of latency.
    cp1 = cp0 ^ CP_W'($urandom_range(1, 3));
    cp_current = cp1;
    check("cp_before_edge", 32'(pll_cp_current), 32'(cp0));
    tick();
    check("cp_after_edge", 32'(pll_cp_current), 32'(cp1));

    // Loss of lock: a short bad burst is tolerated, UNLOCK_CNT bad cycles are not.
    b = $urandom_range(0, 2);
    nbad = $urandom_range(1, UNLOCK_CNT - 1);
    ok_v = ~(3'b001 << b);
    repeat (nbad) tick();
    check("lol_short_lock", 32'(pll_lock), 1);
    ok_v = 3'b111;
    tick();
    ok_v = ~(3'b001 << b);
    repeat (UNLOCK_CNT - 1) tick();
    check("lol_edge_minus1_lock", 32'(pll_lock), 1);
    tick();
    check("lol_lock",  32'(pll_lock), 0);
    check("lol_cnt",   32'(lol_cnt), 1);
    check("lol_state", 32'(state), 2);
    check("lol_trim",  32'(pll_vco_trim), m);
    ok_v = 3'b111;
    wait_lock(64, e);
    check("relock_edges", e, SETTLE_CNT + LOCK_CNT);

    // Manual retune while locked.
    m2 = (m + $urandom_range(1, TRIM_MAX)) % (TRIM_MAX + 1);
    vco_trim_man = TRIM_W'(m2);
    tick();
    check("retune_state", 32'(state), 2);
    check("retune_trim",  32'(pll_vco_trim), m2);
    check("retune_lock",  32'(pll_lock), 0);
    wait_lock(64, e);
    check("retune_lock_edges", e, SETTLE_CNT + LOCK_CNT);
    check("retune_cal_trim", 32'(cal_trim), m2);

    // Bypass request drops back to IDLE and is mirrored one edge later.
    pll_bypass = 1'b1;
    tick();
    check("bypass_state",  32'(state), 0);
    check("bypass_en",     32'(pll_bypass_en), 1);
    check("bypass_enable", 32'(pll_enable), 0);
    pll_bypass = 1'b0; phy_en = 1'b0;
    tick();
    check("bypass_en_off", 32'(pll_bypass_en), 0);

    // Auto band search to a random target band.
    cal_en = 1'b1; auto_good = 1'b1;
    for (int i = 0; i < 2; i++) begin
      t = $urandom_range(0, 7);
      target = TRIM_W'(t);
      phy_en = 1'b1;
      wait_lock(400, e);
      check("auto_lock_edges", e, auto_lock_edges(t));
      check("auto_cal_trim",   32'(cal_trim), t);
      check("auto_trim",       32'(pll_vco_trim), t);
      check("auto_error",      32'(pll_error), 0);
      phy_en = 1'b0;
      tick();
      check("auto_idle", 32'(state), 0);
    end

    // Auto search with no good band: trim saturates, then a retry restarts at 0.
    ok_v = 3'b000;
    phy_en = 1'b1;
    e = 0; tmax = 0;
    while (retry_cnt == 2'd0 && e < 600) begin
      tick();
      e++;
      if (retry_cnt == 2'd0 && int'(pll_vco_trim) > tmax) tmax = int'(pll_vco_trim);
    end
    check("wrap_retry_edge", e, 1 + RST_PULSE + (TRIM_MAX + 1) * (SETTLE_CNT + ACQ_TIMEOUT));
    check("wrap_max_trim",   tmax, TRIM_MAX);
    check("wrap_reload",     32'(pll_vco_trim), 0);
    check("wrap_state",      32'(state), 1);
    phy_en = 1'b0;
    tick();
    cal_en = 1'b0; auto_good = 1'b0;

    // Manual exhaustion, each qualifier in turn held bad.
    for (int k = 0; k < 3; k++) begin
      ok_v = ~(3'b001 << k);
      phy_en = 1'b1;
      e = 0; r1 = -1; r2 = -1;
      while (state != 3'd5 && e < 200) begin
        tick();
        e++;
        if (retry_cnt == 2'd1 && r1 < 0) r1 = e;
        if (retry_cnt == 2'd2 && r2 < 0) r2 = e;
      end
      check("exh_retry1_edge", r1, manual_attempt_end(1));
      check("exh_retry2_edge", r2, manual_attempt_end(2));
      check("exh_error_edge",  e,  manual_attempt_end(MAX_RETRY + 1));
      check("exh_error",   32'(pll_error), 1);
      check("exh_enable",  32'(pll_enable), 0);
      check("exh_reset_n", 32'(pll_reset_n), 0);
      repeat (3) tick();
      check("exh_sticky", 32'(pll_error), 1);
      check("exh_trim",   32'(pll_vco_trim), m2);
      phy_en = 1'b0;
      tick();
      check("exh_idle_state", 32'(state), 0);
      check("exh_idle_error", 32'(pll_error), 0);
      check("exh_idle_retry", 32'(retry_cnt), 0);
    end

    // pll_rst mid-acquire aborts to IDLE on the next edge.
    ok_v = 3'b000;
    phy_en = 1'b1;
    e = 0;
    while (state != 3'd3 && e < 32) begin
      tick();
      e++;
    end
    check("abort_reach_acq", 32'(state), 3);
    pll_rst = 1'b1;
    tick();
    check("abort_state",   32'(state), 0);
    check("abort_enable",  32'(pll_enable), 0);
    check("abort_reset_n", 32'(pll_reset_n), 0);
    pll_rst = 1'b0; phy_en = 1'b0;
    tick();

    // Asynchronous reset while locked.
    ok_v = 3'b111;
    phy_en = 1'b1;
    wait_lock(64, e);
    check("async_pre_lock", 32'(pll_lock), 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async");
    tick();
    rst_n = 1'b1;
    phy_en = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serdesphy_pll_autocal.md
Name: serdesphy_pll_autocal

Overview:
- Next-generation PLL controller for the SerDes PHY, sitting between the CSR block and the analog PLL macro on the 24 MHz reference domain.
- Adds a parametrised VCO trim width and configurable lock, settle, unlock and timeout windows.
- Adds an automatic VCO band search (auto-calibration), bounded restart retries with a reset pulse, and a saturating loss-of-lock counter.
- Gates the 240 MHz TX/RX clock enables on validated lock.

Parameters:
TRIM_W, 4, VCO trim width
CP_W, 2, charge-pump current select width
CNT_W, 16, width of internal timers
RST_PULSE, 16, cycles pll_reset_n is held low in RESTART
SETTLE_CNT, 480, cycles waited after (re)start or trim change before lock is evaluated
LOCK_CNT, 2400, consecutive good cycles required to declare lock
UNLOCK_CNT, 240, consecutive bad cycles in LOCKED before loss-of-lock
ACQ_TIMEOUT, 4800, maximum cycles spent in ACQUIRE per trim code
MAX_RETRY, 3, restarts allowed after trim exhaustion or a manual-mode timeout before ERROR

Ports:
clk_ref_24m input 1 24 MHz reference clock
rst_n input 1 asynchronous active-low reset
phy_en input 1 PHY global enable
pll_rst input 1 CSR PLL reset
pll_bypass input 1 CSR bypass request
cal_en input 1 1 = auto trim search, 0 = manual trim
vco_trim_man input TRIM_W manual trim code
cp_current input CP_W charge-pump select
pll_lock_raw input 1 analog lock
pll_vco_ok input 1 VCO in range
pll_cp_ok input 1 charge pump OK
pll_enable output 1 analog PLL enable
pll_reset_n output 1 analog PLL reset, active-low
pll_bypass_en output 1 analog bypass enable
pll_vco_trim output TRIM_W applied trim code
pll_cp_current output CP_W applied charge-pump select
pll_lock output 1 validated lock
pll_error output 1 calibration/retry failure
clk_240m_en output 1 TX/RX 240 MHz clock enable
cal_trim output TRIM_W trim code at which lock was achieved
retry_cnt output 2 restarts used in the current run
lol_cnt output 8 saturating loss-of-lock event count
state output 3 FSM state, for debug

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk_ref_24m.
- Reset values: all outputs 0 except pll_vco_trim = 2^(TRIM_W-1) (mid-band) and pll_cp_current = 0; state = IDLE.
- Definitions: run = phy_en & !pll_rst & !pll_bypass; good = pll_lock_raw & pll_vco_ok & pll_cp_ok.
- Outputs are decoded directly from registered state (Moore outputs, no extra output stage).
- pll_bypass_en = phy_en & pll_bypass, registered.
- pll_cp_current tracks cp_current with 1-cycle latency.
- State encodings: IDLE=0, RESTART=1, SETTLE=2, ACQUIRE=3, LOCKED=4, ERROR=5.
- Global rule: run=0 in any state → IDLE on the next edge; this includes pll_rst mid-operation and ERROR.
- IDLE: pll_enable=0, pll_reset_n=0, retry_cnt cleared. On run=1 → RESTART, and trim is loaded: cal_en ? 0 : vco_trim_man.
- RESTART: pll_enable=1, pll_reset_n=0 for RST_PULSE cycles → SETTLE.
- SETTLE: pll_enable=1, pll_reset_n=1; after SETTLE_CNT cycles → ACQUIRE.
- ACQUIRE:
  - good_cnt increments on good and clears on !good.
  - LOCK_CNT consecutive good cycles → LOCKED; cal_trim captured.
  - Timeout when tmo_cnt reaches ACQ_TIMEOUT without lock. If lock and timeout occur on the same cycle, lock wins.
  - Timeout with cal_en=1 and trim < max: trim+1 → SETTLE.
  - Timeout otherwise, with retry_cnt < MAX_RETRY: retry_cnt+1, trim reloaded → RESTART.
  - Timeout otherwise, with retries exhausted → ERROR.
- LOCKED:
  - pll_lock=1, clk_240m_en=1.
  - bad_cnt counts consecutive !good and clears on good.
  - UNLOCK_CNT consecutive bad cycles → lol_cnt+1 (saturates at 255), retry_cnt cleared, trim kept → SETTLE. pll_lock drops on that edge.
- ERROR: pll_enable=0, pll_reset_n=0, pll_error=1 (sticky until run=0); trim holds.
- Manual retune: with cal_en=0 and state in SETTLE/ACQUIRE/LOCKED, a change in vco_trim_man → load new trim → SETTLE.
- A cal_en change is sampled only in IDLE.
- Lock latency from the first edge sampling run=1, with good held: RST_PULSE + SETTLE_CNT + LOCK_CNT + 1 edges.
- Timers are cleared on every state entry.
- Trim never wraps past 2^TRIM_W − 1.

Test Plan:
All scenarios use overrides RST_PULSE=2, SETTLE_CNT=4, LOCK_CNT=8, UNLOCK_CNT=4, ACQ_TIMEOUT=16, MAX_RETRY=2.
- Manual lock: cal_en=0, vco_trim_man=5, good=1, run rises → pll_lock=1 exactly 15 edges later; cal_trim=5; clk_240m_en=1; retry_cnt=0.
- Auto search: cal_en=1, good only when pll_vco_trim==3 → trim steps 0,1,2,3; lock at 3; cal_trim=3; pll_error=0.
- Exhaustion: cal_en=0, good=0 → RESTART twice (retry_cnt 1,2), then state=5, pll_error=1; dropping phy_en → IDLE, pll_error=0.
- Loss of lock: after lock, good=0 for 3 cycles → stays locked; good=0 for 4 cycles → pll_lock=0, lol_cnt=1, state=SETTLE, trim unchanged; relock follows.
- Mid-operation abort: assert pll_rst during ACQUIRE → next edge state=0, pll_enable=0, pll_reset_n=0. Assert rst_n low during LOCKED → all outputs at reset values asynchronously.
- Retune and bypass: vco_trim_man changes 5→7 while locked → SETTLE, pll_vco_trim=7. pll_bypass=1 → pll_bypass_en=1, state=IDLE.
